// File: rtl/cla_pkg.sv
// Shared types and sizing for the two-level 32-bit carry-lookahead adder.
package cla_pkg;

    localparam int WIDTH   = 32;
    localparam int GROUP   = 4;
    localparam int NGROUPS = WIDTH / GROUP;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

endpackage

// File: rtl/cla32_final_if.sv
// Operand/result bundle for cla32_final.
// ovf/zero exist only when CLA32_FLAGS_EN is defined.
interface cla32_final_if;
    import cla_pkg::*;

    logic  in_valid;
    word_t a;
    word_t b;
    logic  c_in;
    logic  out_valid;
    word_t s;
    logic  c_out;
`ifdef CLA32_FLAGS_EN
    logic  ovf;
    logic  zero;

    modport master (
        output in_valid, a, b, c_in,
        input  out_valid, s, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in,
        output out_valid, s, c_out, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, c_in,
        input  out_valid, s, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in,
        output out_valid, s, c_out
    );
`endif

endinterface

// File: rtl/cla_group4.sv
// 4-bit lookahead group: internal carries from flattened equations,
// plus group propagate/generate for the second level.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       grp_p,
    output logic       grp_g
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p = a ^ b;
        g = a & b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        s = p ^ c;

        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/cla32_final.sv
// Registered 32-bit two-level CLA adder, one-cycle latency.
// Optional ovf/zero flags under CLA32_FLAGS_EN.
module cla32_final
    import cla_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    cla32_final_if.slave bus
);

    grp_pg_t [NGROUPS-1:0] pg;
    logic    [NGROUPS:0]   c_grp;
    word_t                 sum;

    for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
        cla_group4 u_grp (
            .a     (bus.a[GROUP*k +: GROUP]),
            .b     (bus.b[GROUP*k +: GROUP]),
            .cin   (c_grp[k]),
            .s     (sum[GROUP*k +: GROUP]),
            .grp_p (pg[k].p),
            .grp_g (pg[k].g)
        );
    end

    // Each group carry is a flat OR of product terms, not a G|P*C chain.
    always_comb begin
        logic acc;
        logic term;
        c_grp    = '0;
        c_grp[0] = bus.c_in;
        for (int k = 1; k <= NGROUPS; k++) begin
            term = bus.c_in;
            for (int m = 0; m < k; m++) begin
                term = term & pg[m].p;
            end
            acc = term;
            for (int j = 0; j < k; j++) begin
                term = pg[j].g;
                for (int m = j + 1; m < k; m++) begin
                    term = term & pg[m].p;
                end
                acc = acc | term;
            end
            c_grp[k] = acc;
        end
    end

    word_t s_d, s_q;
    logic  c_out_d, c_out_q;
    logic  out_valid_d, out_valid_q;

    always_comb begin
        s_d         = s_q;
        c_out_d     = c_out_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            s_d         = sum;
            c_out_d     = c_grp[NGROUPS];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
    assign bus.out_valid = out_valid_q;

`ifdef CLA32_FLAGS_EN
    logic ovf_d, ovf_q;
    logic zero_d, zero_q;

    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (bus.in_valid) begin
            ovf_d  = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
                  && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            zero_d = (sum == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_cla32_final.sv
// Directed and random checks for cla32_final.
module tb_cla32_final;
    import cla_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cla32_final_if bus ();

    cla32_final dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic v, input word_t x,
                         input word_t y, input logic c);
        bus.in_valid = v;
        bus.a        = x;
        bus.b        = y;
        bus.c_in     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.c_in     = 1'b0;
        #2;
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_init: got v=%b c=%b s=%h want 0",
                     bus.out_valid, bus.c_out, bus.s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s} !== {2'b11, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_pre: got v=%b c=%b s=%h want v=1 c=1 s=0",
                     bus.out_valid, bus.c_out, bus.s);
        end
        bus.a = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b c=%b s=%h want 0",
                     bus.out_valid, bus.c_out, bus.s);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got v=%b c=%b s=%h want 0",
                     bus.out_valid, bus.c_out, bus.s);
        end
`ifdef CLA32_FLAGS_EN
        n_checks++;
        if ({bus.ovf, bus.zero} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got ovf=%b zero=%b want 0 0",
                     bus.ovf, bus.zero);
        end
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        word_t va [7];
        word_t vb [7];
        word_t vs [7];
        va = '{32'h0000_FFDC, 32'd65535, 32'd1021201, 32'd6553500,
               32'd65455345, 32'd65535656, 32'd65555535};
        vb = '{32'h64, 32'd11111, 32'd1457454, 32'd1111145,
               32'd11145411, 32'd11112441, 32'd11114541};
        vs = '{32'h0001_0040, 32'd76646, 32'd2478655, 32'd7664645,
               32'd76600756, 32'd76648097, 32'd76670076};
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, va[i], vb[i], 1'b0);
            n_checks++;
            if ({bus.out_valid, bus.c_out, bus.s} !== {2'b10, vs[i]}) begin
                n_fail++;
                $display("FAIL directed_%0d: got v=%b c=%b s=%0d want %0d",
                         i, bus.out_valid, bus.c_out, bus.s, vs[i]);
            end
        end
    endtask

    task automatic test_wrap();
        apply(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s} !== {2'b11, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_cin: got v=%b c=%b s=%h want c=1 s=0",
                     bus.out_valid, bus.c_out, bus.s);
        end
`ifdef CLA32_FLAGS_EN
        n_checks++;
        if ({bus.ovf, bus.zero} !== 2'b01) begin
            n_fail++;
            $display("FAIL wrap_flags: got ovf=%b zero=%b want 0 1",
                     bus.ovf, bus.zero);
        end
`endif
        apply(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s}
            !== {2'b11, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL wrap_all1: got c=%b s=%h want c=1 s=ffffffff",
                     bus.c_out, bus.s);
        end
    endtask

    task automatic test_propagation();
        apply(1'b1, 32'h0000_000F, 32'h1, 1'b0);
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s} !== {2'b10, 32'h10}) begin
            n_fail++;
            $display("FAIL prop_grp0: got c=%b s=%h want c=0 s=10",
                     bus.c_out, bus.s);
        end
        apply(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s}
            !== {2'b10, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL prop_full: got c=%b s=%h want c=0 s=80000000",
                     bus.c_out, bus.s);
        end
`ifdef CLA32_FLAGS_EN
        n_checks++;
        if ({bus.ovf, bus.zero} !== 2'b10) begin
            n_fail++;
            $display("FAIL prop_flags: got ovf=%b zero=%b want 1 0",
                     bus.ovf, bus.zero);
        end
`endif
        apply(1'b1, 32'h00FF_FFFF, 32'h0, 1'b1);
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s}
            !== {2'b10, 32'h0100_0000}) begin
            n_fail++;
            $display("FAIL prop_cin: got c=%b s=%h want c=0 s=01000000",
                     bus.c_out, bus.s);
        end
    endtask

    task automatic test_valid_gating();
        apply(1'b1, 32'h8000_0000, 32'h8000_0001, 1'b0);
        n_checks++;
        if ({bus.out_valid, bus.c_out, bus.s} !== {2'b11, 32'h1}) begin
            n_fail++;
            $display("FAIL gate_load: got c=%b s=%h want c=1 s=1",
                     bus.c_out, bus.s);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, $urandom, $urandom, 1'($urandom));
            n_checks++;
            if ({bus.out_valid, bus.c_out, bus.s} !== {2'b01, 32'h1}) begin
                n_fail++;
                $display("FAIL gate_hold_%0d: got v=%b c=%b s=%h want v=0 c=1 s=1",
                         i, bus.out_valid, bus.c_out, bus.s);
            end
        end
    endtask

    task automatic test_back_to_back();
        word_t va [4];
        word_t vb [4];
        word_t vs [4];
        va = '{32'h1, 32'h10, 32'h100, 32'hFFFF_0000};
        vb = '{32'h2, 32'h20, 32'h200, 32'h0001_0000};
        vs = '{32'h3, 32'h30, 32'h300, 32'h0};
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, va[i], vb[i], 1'b0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.s !== vs[i]
                || bus.c_out !== (i == 3)) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b c=%b s=%h want s=%h",
                         i, bus.out_valid, bus.c_out, bus.s, vs[i]);
            end
        end
    endtask

    task automatic test_random();
        word_t       x;
        word_t       y;
        logic        c;
        logic [32:0] ref_sum;
        int          errs;
        errs = 0;
        for (int i = 0; i < 10000; i++) begin
            x       = $urandom;
            y       = $urandom;
            c       = 1'($urandom);
            ref_sum = {1'b0, x} + {1'b0, y} + {32'd0, c};
            apply(1'b1, x, y, c);
            n_checks++;
            if (bus.out_valid !== 1'b1
                || {bus.c_out, bus.s} !== ref_sum) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random_%0d: %h+%h+%b got %b_%h want %h",
                             i, x, y, c, bus.c_out, bus.s, ref_sum);
                errs++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_wrap();
        test_propagation();
        test_valid_gating();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla32_final.md
Name: cla32_final

Overview:
- Registered 32-bit carry-lookahead adder: s = a + b + c_in, with carry-out.
- Two-level lookahead: 4-bit CLA groups with group propagate/generate; second-level lookahead unit produces the group carries.
- One-cycle pipelined arithmetic primitive for the datapath/ALU; result is registered with a valid flag.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- GROUP, 4, bits per first-level CLA group; WIDTH/GROUP = 8 groups.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid this cycle
- a  in  32  operand A (unsigned or two's complement)
- b  in  32  operand B
- c_in  in  1  carry into bit 0
- out_valid  out  1  s/c_out hold the result of the previous accepted operation
- s  out  32  sum, modulo 2^32
- c_out  out  1  carry out of bit 31

Behaviour:
- Reset (rst_n=0, asynchronous): s=0, c_out=0, out_valid=0 immediately. Hold these values until the first rising clk after rst_n deasserts.
- Per bit: p_i = a_i ^ b_i, g_i = a_i & b_i.
- Group k covers bits 4k..4k+3:
  - Internal carries come from lookahead equations only; no ripple between bits.
  - Group P = AND of the group's four p bits.
  - Group G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Second level computes group carries C_{k+1} = G_k | P_k C_k, with C_0 = c_in.
  - Implement these as flattened lookahead terms, not a chain.
- s_i = p_i ^ c_i. c_out = C_8.
- Sum logic is purely combinational from a, b and c_in.
- Registers load only on a rising clk edge with in_valid=1. Registered values: {c_out, s} = a + b + c_in, and out_valid <= 1.
- Rising clk with in_valid=0: out_valid <= 0; s and c_out hold their previous values.
- Latency is exactly 1 cycle. Throughput is 1 operation per cycle with no backpressure.
- Wrap-around: sums at or above 2^32 wrap modulo 2^32, with c_out=1. No saturation.
- Reset asserted mid-stream: the pending result is discarded and outputs clear at once.
- X on inputs while in_valid=0 must not corrupt the held s or c_out.

Optional Feature:
- Macro: CLA32_FLAGS_EN.
- Defined: adds two outputs, ovf (1 bit) and zero (1 bit).
  - Both register alongside s under the same in_valid/reset rules; reset value is 0.
  - ovf = (a[31] == b[31]) && (s[31] != a[31]), i.e. signed overflow, which includes the effect of c_in.
  - zero = (s == 0).
- Undefined: the ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package cla_pkg holds:
  - WIDTH=32, GROUP=4, NGROUPS=8
  - typedef word_t (logic [31:0])
  - typedef grp_pg_t (struct {p, g})
- One sub-module, cla_group4, instantiated 8 times.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], P, G.
- The second-level lookahead and the output registers live in cla32_final.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> s=0, c_out=0, out_valid=0 immediately, without waiting for a clock edge.
- Directed sums, c_in=0, one per cycle; each result appears with out_valid=1 one cycle after its operands, c_out=0:
  - 0x0000FFDC + 0x64 -> 0x00010040
  - 65535 + 11111 -> 76646
  - 1021201 + 1457454 -> 2478655
  - 6553500 + 1111145 -> 7664645
  - 65455345 + 11145411 -> 76600756
  - 65535656 + 11112441 -> 76648097
  - 65555535 + 11114541 -> 76670076
- Wrap and carry-in:
  - 0xFFFFFFFF + 0 with c_in=1 -> s=0, c_out=1 (and zero=1 with CLA32_FLAGS_EN)
  - 0xFFFFFFFF + 0xFFFFFFFF with c_in=1 -> s=0xFFFFFFFF, c_out=1
- Full carry propagation across group boundaries: 0x0000000F + 0x1 -> 0x10; 0x7FFFFFFF + 1 -> 0x80000000, c_out=0 (ovf=1 with CLA32_FLAGS_EN).
- Valid gating: in_valid=0 for 3 cycles with random a/b -> out_valid=0 and s/c_out unchanged. Back-to-back in_valid=1 -> one result per cycle, in order.
- Random: 10k random a, b, c_in -> {c_out, s} matches a 33-bit reference sum, checked one cycle later.
